// File: rtl/segment_spi_sender_pkg.sv
// Shared definitions for the motion-segment SPI link (sender and receiver side).
package segment_spi_sender_pkg;

  typedef enum logic [7:0] {
    CMD_NO_OP      = 8'h00,
    CMD_STATUS     = 8'h01,
    CMD_WRITE_FIFO = 8'h02
  } command_t;

  typedef logic [31:0] MotionSegment;

  localparam int FIFO_SLOTS        = 16;
  localparam int FIFO_RECORD_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_WR_CMD,
    ST_WR_DATA,
    ST_TAIL,
    ST_GAP,
    ST_WAIT
  } state_t;

  // A reply larger than the FIFO depth is treated as "completely empty".
  function automatic logic [7:0] clamp_slots(input logic [7:0] raw);
    return (raw > 8'(FIFO_SLOTS)) ? 8'(FIFO_SLOTS) : raw;
  endfunction

  // Byte idx of a segment, byte 0 being the least significant.
  function automatic logic [7:0] segment_byte(input MotionSegment seg, input logic [1:0] idx);
    return seg[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte engine: generates SCK and shifts one byte out (MSB first) while
// shifting one byte in. done is asserted in the last cycle of a byte, and a new
// start is accepted in that same cycle so bytes can run back to back.
module spi_byte_shifter
  import segment_spi_sender_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  logic        active_q, active_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        half_end;

  assign half_end = (div_q == 16'(CLK_DIV - 1));
  assign done     = active_q && sck_q && half_end && (bit_q == 3'd7);
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign rx_byte  = rx_q;

  // Half-period timing, MISO capture on rise, MOSI advance on fall, byte (re)start.
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (active_q) begin
      if (half_end) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[6:0], miso};
        end else begin
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            active_d = 1'b0;
          end else begin
            bit_d  = bit_q + 3'd1;
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
          end
        end
      end else begin
        div_d = div_q + 16'd1;
      end
    end
    if (start && (!active_q || done)) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      tx_d     = tx_byte;
      mosi_d   = tx_byte[7];
    end
  end

  // Shifter state register; reset parks SCK and MOSI low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/segment_spi_sender.sv
// Streams motion segments to a remote FIFO over SPI, using a credit scheme fed by
// status polls. Optional macro SEGMENT_SPI_SENDER_BATCH_EN lets one write
// transaction carry several segments; without it each write carries exactly one.
module segment_spi_sender
  import segment_spi_sender_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int CS_GAP        = 4,
  parameter int POLL_INTERVAL = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  MotionSegment seg_data,
  input  logic         seg_valid,
  output logic         seg_ready,
  output logic         spi_sck,
  output logic         spi_mosi,
  output logic         spi_cs,
  input  logic         spi_miso,
  output logic [7:0]   free_slots,
  output logic         busy
);

`ifdef SEGMENT_SPI_SENDER_BATCH_EN
  localparam bit BATCH_EN = 1'b1;
`else
  localparam bit BATCH_EN = 1'b0;
`endif

  localparam logic [1:0] LAST_IDX = 2'(FIFO_RECORD_WORDS - 1);

  state_t       state_q, state_d;
  logic [4:0]   credits_q, credits_d;
  logic [7:0]   free_slots_q, free_slots_d;
  MotionSegment seg_q, seg_d;
  logic [1:0]   idx_q, idx_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         cs_q, cs_d;
  logic         zero_reply_q, zero_reply_d;

  logic         sh_start;
  logic [7:0]   sh_tx;
  logic         sh_done;
  logic [7:0]   sh_rx;
  logic         can_latch;
  logic         seg_ready_c;

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (sh_start),
    .tx_byte (sh_tx),
    .miso    (spi_miso),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .done    (sh_done),
    .rx_byte (sh_rx)
  );

  assign can_latch  = seg_valid && (credits_q != 5'd0);
  assign seg_ready  = seg_ready_c;
  assign spi_cs     = cs_q;
  assign free_slots = free_slots_q;
  assign busy       = (state_q != ST_IDLE);

  // Transaction sequencing: picks poll or write, feeds bytes to the shifter, and
  // times the CS tail, the inter-transaction gap and the back-off after an empty poll.
  always_comb begin
    state_d      = state_q;
    credits_d    = credits_q;
    free_slots_d = free_slots_q;
    seg_d        = seg_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    cs_d         = cs_q;
    zero_reply_d = zero_reply_q;
    sh_start     = 1'b0;
    sh_tx        = CMD_NO_OP;
    seg_ready_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (seg_valid) begin
          cs_d     = 1'b0;
          sh_start = 1'b1;
          if (credits_q == 5'd0) begin
            sh_tx   = CMD_STATUS;
            state_d = ST_POLL;
          end else begin
            sh_tx   = CMD_WRITE_FIFO;
            state_d = ST_WR_CMD;
          end
        end
      end
      ST_POLL: begin
        if (sh_done) begin
          credits_d    = 5'(clamp_slots(sh_rx));
          free_slots_d = clamp_slots(sh_rx);
          zero_reply_d = (sh_rx == 8'd0);
          cnt_d        = '0;
          state_d      = ST_TAIL;
        end
      end
      ST_WR_CMD: begin
        if (sh_done) begin
          if (can_latch) begin
            seg_d       = seg_data;
            seg_ready_c = 1'b1;
            credits_d   = credits_q - 5'd1;
            idx_d       = 2'd0;
            sh_start    = 1'b1;
            sh_tx       = segment_byte(seg_data, 2'd0);
            state_d     = ST_WR_DATA;
          end else begin
            cnt_d   = '0;
            state_d = ST_TAIL;
          end
        end
      end
      ST_WR_DATA: begin
        if (sh_done) begin
          if (idx_q != LAST_IDX) begin
            idx_d    = idx_q + 2'd1;
            sh_start = 1'b1;
            sh_tx    = segment_byte(seg_q, idx_q + 2'd1);
          end else if (BATCH_EN && can_latch) begin
            seg_d       = seg_data;
            seg_ready_c = 1'b1;
            credits_d   = credits_q - 5'd1;
            idx_d       = 2'd0;
            sh_start    = 1'b1;
            sh_tx       = segment_byte(seg_data, 2'd0);
          end else begin
            cnt_d   = '0;
            state_d = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        if (cnt_q == 16'(CLK_DIV - 1)) begin
          cs_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 16'(CS_GAP - 1)) begin
          cnt_d        = '0;
          zero_reply_d = 1'b0;
          state_d      = zero_reply_q ? ST_WAIT : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 16'(POLL_INTERVAL - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cs_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register; reset abandons any transaction and forgets all credits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      credits_q    <= '0;
      free_slots_q <= '0;
      seg_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      cs_q         <= 1'b1;
      zero_reply_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      free_slots_q <= free_slots_d;
      seg_q        <= seg_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      cs_q         <= cs_d;
      zero_reply_q <= zero_reply_d;
    end
  end

endmodule

// File: doc/segment_spi_sender.md
SEGMENT_SPI_SENDER -- requirements
Module: segment_spi_sender

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in clk cycles, minimum 1.
REQ-002 SHALL have parameter CS_GAP, default 4: minimum clk cycles spi_cs stays high between transactions.
REQ-003 SHALL have parameter POLL_INTERVAL, default 64: clk cycles to wait before re-polling after a zero free-slot reply.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 seg_data  in  32  motion segment to send.
REQ-008 seg_valid  in  1  seg_data valid.
REQ-009 seg_ready  out  1  segment accepted this cycle.
REQ-010 spi_sck  out  1  SPI clock, idles low.
REQ-011 spi_mosi  out  1  main-out data, MSB first.
REQ-012 spi_cs  out  1  chip select, active low.
REQ-013 spi_miso  in  1  secondary-out data.
REQ-014 free_slots  out  8  last polled free-slot count, clamped.
REQ-015 busy  out  1  high while state is not IDLE.

Function
REQ-016 SHALL use SPI mode 0: MOSI changes on SCK falling edge or CS assertion; MISO is sampled on SCK rising edge; 8 bits per byte; each byte takes 16*CLK_DIV clk cycles.
REQ-017 SHALL assert spi_cs low one half-period before the first SCK rise, and deassert it one half-period after the last SCK fall.
REQ-018 SHALL keep a 5-bit credit counter, reset to 0.
- Decrement by one per segment accepted.
- Never wrap below 0.
REQ-019 States and transitions:
- IDLE: seg_valid and credits==0 -> POLL; seg_valid and credits>0 -> WR_CMD.
- POLL: one-byte transaction sending CMD_STATUS (0x01); the received byte is clamped to 16 and loaded into credits and free_slots; then -> GAP.
- WR_CMD: sends CMD_WRITE_FIFO (0x02) -> WR_DATA.
- WR_DATA: sends 4 segment bytes, least significant byte first.
- GAP: CS high for CS_GAP cycles -> IDLE, or -> WAIT if the poll returned 0.
- WAIT: POLL_INTERVAL cycles -> IDLE.
REQ-020 seg_ready SHALL pulse for exactly one cycle when the segment is latched.
- The segment is latched at the start of its first data byte.
- Latching occurs only if seg_valid is high and credits>0.
REQ-021 At each segment boundary in WR_DATA: continue with the next segment if batching is allowed, seg_valid is high and credits>0; otherwise close the transaction -> GAP.
REQ-022 SHALL NOT accept a segment while credits==0; credits are refreshed only by POLL.
REQ-023 seg_data changes while seg_valid is high and seg_ready is low SHALL be allowed; the latched copy is what gets transmitted.
REQ-024 seg_valid dropping mid-transaction SHALL NOT abort the segment in flight; the transaction closes at the next segment boundary.

Reset
REQ-025 On reset assertion, immediately and asynchronously:
- spi_cs=1, spi_sck=0, spi_mosi=0, seg_ready=0, busy=0, free_slots=0.
- credits=0, state=IDLE.
REQ-026 Reset mid-transaction SHALL drop the in-flight segment; the transaction is truncated and not resumed.

Configuration
REQ-027 Macro SEGMENT_SPI_SENDER_BATCH_EN:
- Defined: a write transaction carries up to credits segments (1 command byte + 4 bytes per segment).
- Undefined: exactly one segment per write transaction (always 5 bytes), and CS deasserts between segments.

Structure
REQ-028 The shared package SHALL hold:
- command_t (CMD_NO_OP=0, CMD_STATUS=1, CMD_WRITE_FIFO=2).
- MotionSegment (32-bit).
- FIFO_SLOTS=16 and FIFO_RECORD_WORDS=4.
- The receiving side imports the same package.
REQ-029 SHALL instantiate one sub-module, spi_byte_shifter.
- It handles SCK generation and 8-bit shift in/out, with a start/done handshake.
- CS and sequencing remain in segment_spi_sender.

Verification
REQ-030 After reset, seg_data=0x44332211 with seg_valid held and MISO model replying 16:
- Status transaction MOSI 0x01.
- Then write transaction MOSI 0x02,0x11,0x22,0x33,0x44.
- free_slots=16, credits=15, one seg_ready pulse.
REQ-031 MISO replies 0 then 2:
- No write after the first poll.
- Second poll starts no earlier than CS_GAP+POLL_INTERVAL (68) cycles after CS rise.
- Then writes proceed.
REQ-032 Three queued segments, poll reply 2, BATCH_EN defined:
- One 9-byte transaction.
- Then a poll before the third segment.
- Undefined: two separate 5-byte transactions, then a poll.
REQ-033 Reset asserted during byte 3 of a write:
- spi_cs=1, spi_sck=0 in the same cycle.
- After release, the next seg_valid starts with POLL (credits 0).
REQ-034 CLK_DIV=2:
- Each byte spans 32 clk cycles.
- MOSI is stable 2 cycles before and after every SCK rise.
- CS-high gap is at least 4 cycles.
REQ-035 MISO reply 0xFF -> free_slots=16, credits=16.
